// File: rtl/blink_driver.sv
// Purpose: turn the upstream one-hot blink rate into a square-wave LED drive plus a per-edge pulse.
// Latency: one cycle from en/rate sampled at a clock edge to led/toggle/rate_idx (all registered).
// Backpressure: none; en is a level enable and rate is only latched at phase boundaries.
module blink_driver #(
  parameter int BASE_HALF = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] rate,
  output logic       led,
  output logic       toggle,
  output logic [1:0] rate_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             led_q, led_d;
  logic             tog_q, tog_d;

  logic             rate_vld;
  logic [1:0]       rate_dec;
  logic [CNT_W-1:0] half_m1;
  logic             phase_end;

  // Highest set bit wins, so a multi-bit code from the shifter picks the fastest rate present.
  always_comb begin
    rate_vld = |rate;
    if (rate[3])      rate_dec = 2'd3;
    else if (rate[2]) rate_dec = 2'd2;
    else if (rate[1]) rate_dec = 2'd1;
    else              rate_dec = 2'd0;
  end

  // Last count of the current phase, taken from the rate latched at the phase start.
  always_comb begin
    case (idx_q)
      2'd0:    half_m1 = CNT_W'(BASE_HALF * 8 - 1);
      2'd1:    half_m1 = CNT_W'(BASE_HALF * 4 - 1);
      2'd2:    half_m1 = CNT_W'(BASE_HALF * 2 - 1);
      default: half_m1 = CNT_W'(BASE_HALF - 1);
    endcase
    phase_end = (cnt_q == half_m1);
  end

  // Next state: enter ON from IDLE, flip ON<->OFF at phase end, drop to IDLE on disable or bad rate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    led_d   = led_q;
    tog_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        led_d = 1'b0;
        if (en && rate_vld) begin
          // No toggle on entry: toggle marks ON<->OFF edges only.
          state_d = ON;
          idx_d   = rate_dec;
          led_d   = 1'b1;
        end
      end
      ON, OFF: begin
        if (!en) begin
          // Phase position is discarded; re-enable starts a full ON phase.
          state_d = IDLE;
          cnt_d   = '0;
          led_d   = 1'b0;
        end else if (phase_end) begin
          cnt_d = '0;
          if (rate_vld) begin
            state_d = (state_q == ON) ? OFF : ON;
            idx_d   = rate_dec;
            led_d   = ~led_q;
            tog_d   = 1'b1;
          end else begin
            // Invalid rate only takes effect here, so the running phase is never cut short.
            state_d = IDLE;
            led_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        led_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset also clears the latched rate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      led_q   <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      tog_q   <= tog_d;
    end
  end

  assign led      = led_q;
  assign toggle   = tog_q;
  assign rate_idx = idx_q;

endmodule

// File: tb/tb_blink_driver.sv
// Purpose: directed check of blink_driver waveforms against hand-derived led/toggle/rate_idx patterns.
// Latency: outputs sampled 1 time unit after each rising edge; inputs changed right after sampling.
// Backpressure: none; every wait is a fixed number of cycles.
module tb_blink_driver;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] rate;
  logic       led;
  logic       toggle;
  logic [1:0] rate_idx;

  int n_checks;
  int n_fail;

  blink_driver #(
    .BASE_HALF(2),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .rate    (rate),
    .led     (led),
    .toggle  (toggle),
    .rate_idx(rate_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_led, input logic e_tog,
                            input logic [1:0] e_idx);
    check({tag, ".led"}, 32'(led), 32'(e_led));
    check({tag, ".toggle"}, 32'(toggle), 32'(e_tog));
    check({tag, ".rate_idx"}, 32'(rate_idx), 32'(e_idx));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b0;
    en   = 1'b1;
    rate = 4'b1000;

    // Reset held 3 cycles dominates en/rate.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("reset[%0d]", i), 1'b0, 1'b0, 2'd0);
    end
    rst = 1'b1;

    // Fastest rate: led 1,1,0,0...; toggle every 2nd cycle from first OFF cycle.
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      check_outs($sformatf("fast[%0d]", i), ((i / 2) % 2) == 0, (i > 0) && (i % 2 == 0), 2'd3);
    end
    en = 1'b0;
    tick();
    check_outs("fast_off", 1'b0, 1'b0, 2'd3);

    // Slowest rate: 16 high, 16 low, toggle once per 16 cycles after first ON phase.
    rate = 4'b0001;
    en   = 1'b1;
    tick();
    for (int i = 0; i < 48; i++) begin
      if (i > 0) tick();
      check_outs($sformatf("slow[%0d]", i), ((i / 16) % 2) == 0, (i > 0) && (i % 16 == 0), 2'd0);
    end
    en = 1'b0;
    tick();
    check_outs("slow_off", 1'b0, 1'b0, 2'd0);

    // Mid-phase change at cnt=5: ON keeps 16 cycles, then OFF/ON of 2 cycles at idx 3.
    en = 1'b1;
    tick();
    for (int i = 0; i < 21; i++) begin
      if (i > 0) tick();
      check_outs($sformatf("midchg[%0d]", i),
                 (i < 16) ? 1'b1 : (((i - 16) / 2) % 2 == 1),
                 (i >= 16) && ((i - 16) % 2 == 0),
                 (i < 16) ? 2'd0 : 2'd3);
      if (i == 5) rate = 4'b1000;
    end
    en = 1'b0;
    tick();
    check_outs("midchg_off", 1'b0, 1'b0, 2'd3);

    // Disable at cnt=3 of an H=8 ON phase, re-enable two cycles later.
    rate = 4'b0010;
    en   = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check_outs($sformatf("dis_on[%0d]", i), 1'b1, 1'b0, 2'd1);
    end
    en = 1'b0;
    tick();
    check_outs("dis_edge", 1'b0, 1'b0, 2'd1);
    tick();
    check_outs("dis_idle", 1'b0, 1'b0, 2'd1);
    en = 1'b1;
    tick();
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      check_outs($sformatf("reen[%0d]", j), j < 8, j == 8, 2'd1);
    end
    en = 1'b0;
    tick();

    // Multi-bit rate 0110 -> idx 2, H=4; rate cleared mid-OFF -> finish phase, then IDLE.
    rate = 4'b0110;
    en   = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      check_outs($sformatf("inval[%0d]", i), i < 4, i == 4, 2'd2);
      if (i == 5) rate = 4'b0000;
    end

    // Reset mid-phase clears led and the latched rate.
    rate = 4'b1000;
    tick();
    check_outs("rst_mid_on", 1'b1, 1'b0, 2'd3);
    rst = 1'b0;
    tick();
    check_outs("rst_mid", 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    tick();
    check_outs("rst_release", 1'b1, 1'b0, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
